fir_block_sequencer: RTL and testbench

- Sequences one shared FIR_filter core, which advances its delay line every clock and has no clock enable, over block-oriented sample streams.
- Buffers a whole input block, clears the core, streams the block gap-free plus zero-padding tail, captures outputs at a fixed core latency, and re-streams them on a valid/ready master port.
- Sits between the bus-side sample interface and the FIR (LLKI-wrapped) core instance.

---
 rtl/fir_block_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_fir_block_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_block_sequencer.sv
// Block sequencer for a free-running FIR core: buffers a block, clears the core, streams it
// with a zero tail and captures results. Optional key gating: FIR_BLOCK_SEQ_KEYGATE_EN.
module fir_block_sequencer #(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned FIR_LAT    = 1,
  parameter int unsigned TAIL       = 31,
  parameter int unsigned CLR_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  input  logic        cfg_start,
  input  logic [15:0] cfg_len,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        key_ready,
  output logic        fir_reset,
  output logic [31:0] fir_in,
  input  logic [31:0] fir_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [16:0] DepthW = 17'(DEPTH);
  localparam logic [16:0] TailW  = 17'(TAIL);
  localparam logic [16:0] LatW   = 17'(FIR_LAT);
  localparam logic [15:0] ClrLast = 16'((CLR_CYCLES > 0) ? CLR_CYCLES - 1 : 0);

  typedef enum logic [2:0] {StIdle, StLoad, StClear, StRun, StFlush, StDrain} state_e;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] clr_q, clr_d;
  logic        err_q, err_d;
  logic [31:0] fir_in_q, fir_in_d;

  // Input FIFO
  logic [31:0]   in_mem [DEPTH];
  logic [AW-1:0] in_wptr_q, in_rptr_q;
  logic [CW-1:0] in_count_q;
  logic          in_push, in_pop;
  logic [31:0]   in_head;

  // Output FIFO
  logic [31:0]   out_mem [DEPTH];
  logic [AW-1:0] out_wptr_q, out_rptr_q;
  logic [CW-1:0] out_count_q;
  logic          out_push, out_pop, out_flush;

  logic [16:0] cnt_x, len_x, len_tail, cfg_len_tail, out_free;
  logic        cap_active, cap_last;

  assign s_ready = ~in_count_q[AW];
  assign in_push = s_valid & s_ready;
  assign in_head = in_mem[in_rptr_q];

  assign m_valid = (out_count_q != '0);
  assign m_data  = m_valid ? out_mem[out_rptr_q] : '0;
  assign out_pop = m_valid & m_ready;

  assign cnt_x        = {1'b0, cnt_q};
  assign len_x        = {1'b0, len_q};
  assign len_tail     = len_x + TailW;
  assign cfg_len_tail = {1'b0, cfg_len} + TailW;
  assign out_free     = DepthW - 17'(out_count_q);

  assign cap_active = (state_q == StRun) || (state_q == StFlush) || (state_q == StDrain);
  assign out_push   = cap_active && (cnt_x >= LatW) && (cnt_x < LatW + len_tail) && !out_flush;
  assign cap_last   = cap_active && (cnt_x == LatW + len_tail - 17'd1);

  assign busy      = (state_q != StIdle);
  assign fir_reset = (state_q == StIdle) || (state_q == StLoad) || (state_q == StClear);
  assign fir_in    = fir_in_q;
  assign err       = err_q;

`ifndef FIR_BLOCK_SEQ_KEYGATE_EN
  logic unused_key_ready;
  assign unused_key_ready = key_ready;
`endif

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    clr_d     = clr_q;
    err_d     = err_q;
    fir_in_d  = '0;
    in_pop    = 1'b0;
    out_flush = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          if (cfg_len == 16'd0 || cfg_len_tail > DepthW
`ifdef FIR_BLOCK_SEQ_KEYGATE_EN
              || !key_ready
`endif
              ) begin
            err_d = 1'b1;
          end else begin
            len_d   = cfg_len;
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        clr_d = '0;
        cnt_d = '0;
        if (17'(in_count_q) >= len_x && out_free >= len_tail) state_d = StClear;
      end
      StClear: begin
        // The first sample is popped here so it sits on fir_in in the first RUN cycle.
        if (clr_q == ClrLast) begin
          in_pop   = 1'b1;
          fir_in_d = in_head;
          cnt_d    = '0;
          state_d  = StRun;
        end else begin
          clr_d = clr_q + 16'd1;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_x + 17'd1 < len_x) begin
          in_pop   = 1'b1;
          fir_in_d = in_head;
        end else begin
          state_d = (TAIL == 0) ? StDrain : StFlush;
        end
      end
      StFlush: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_x == len_tail - 17'd1) state_d = StDrain;
      end
      StDrain: cnt_d = cnt_q + 16'd1;
      default: state_d = StIdle;
    endcase

    if (cap_last) begin
      done    = 1'b1;
      state_d = StIdle;
    end

`ifdef FIR_BLOCK_SEQ_KEYGATE_EN
    // Losing the key aborts the block; unread input words stay queued.
    if (busy && !key_ready) begin
      done      = 1'b0;
      in_pop    = 1'b0;
      fir_in_d  = '0;
      out_flush = 1'b1;
      err_d     = 1'b1;
      state_d   = StIdle;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      len_q    <= '0;
      cnt_q    <= '0;
      clr_q    <= '0;
      err_q    <= 1'b0;
      fir_in_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      clr_q    <= clr_d;
      err_q    <= err_d;
      fir_in_q <= fir_in_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wptr_q] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_wptr_q  <= '0;
      in_rptr_q  <= '0;
      in_count_q <= '0;
    end else begin
      if (in_push) in_wptr_q <= in_wptr_q + 1'b1;
      if (in_pop)  in_rptr_q <= in_rptr_q + 1'b1;
      in_count_q <= in_count_q + CW'(in_push) - CW'(in_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (out_push) out_mem[out_wptr_q] <= fir_out;
  end

  always_ff @(posedge clk) begin
    if (reset || out_flush) begin
      out_wptr_q  <= '0;
      out_rptr_q  <= '0;
      out_count_q <= '0;
    end else begin
      if (out_push) out_wptr_q <= out_wptr_q + 1'b1;
      if (out_pop)  out_rptr_q <= out_rptr_q + 1'b1;
      out_count_q <= out_count_q + CW'(out_push) - CW'(out_pop);
    end
  end

endmodule

// File: tb/tb_fir_block_sequencer.sv
// Self-checking bench for fir_block_sequencer with an identity core and an output scoreboard.
module tb_fir_block_sequencer;

  localparam int unsigned DEPTH      = 16;
  localparam int unsigned FIR_LAT    = 1;
  localparam int unsigned TAIL       = 3;
  localparam int unsigned CLR_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_len = '0;
  logic        busy, done, err;
  logic        key_ready = 1'b1;
  logic        fir_reset;
  logic [31:0] fir_in;
  logic [31:0] fir_out;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  fir_block_sequencer #(
    .DEPTH     (DEPTH),
    .FIR_LAT   (FIR_LAT),
    .TAIL      (TAIL),
    .CLR_CYCLES(CLR_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .cfg_start(cfg_start),
    .cfg_len  (cfg_len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .key_ready(key_ready),
    .fir_reset(fir_reset),
    .fir_in   (fir_in),
    .fir_out  (fir_out)
  );

  always #5 clk = ~clk;

  // Identity core, one clock of latency, held at zero while in reset.
  always_ff @(posedge clk) begin
    if (fir_reset) fir_out <= '0;
    else           fir_out <= fir_in;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!reset && m_valid && m_ready) begin
      if (exp_q.size() == 0) check_eq("sb_extra", 32'(exp_q.size()), 32'd1);
      else                   check_eq("sb_data", m_data, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_samples(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = base + 32'(i);
      for (int w = 0; w < 200 && !s_ready; w++) tick();
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic expect_block(input logic [31:0] base, input int len);
    for (int i = 0; i < len; i++) exp_q.push_back(base + 32'(i));
    for (int i = 0; i < int'(TAIL); i++) exp_q.push_back(32'd0);
  endtask

  task automatic start_block(input int len);
    cfg_start = 1'b1;
    cfg_len   = 16'(len);
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check_eq("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_fir_in(input logic [31:0] val, input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (fir_in == val) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("fir_in_reached", 32'(seen), 32'd1);
  endtask

  initial begin
    int d0;
    int n;
    bit held;

    tick();
    tick();
    @(negedge clk);
    check_eq("rst_s_ready", 32'(s_ready), 32'd1);
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_m_data", m_data, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_fir_reset", 32'(fir_reset), 32'd1);
    check_eq("rst_fir_in", fir_in, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Basic block: 1,2,3,4 then TAIL zeros.
    push_samples(32'd1, 4);
    expect_block(32'd1, 4);
    d0 = done_cnt;
    start_block(4);
    wait_done(100);
    wait_drain(50);
    check_eq("basic_done_once", 32'(done_cnt - d0), 32'd1);
    check_eq("basic_err", 32'(err), 32'd0);

    // Illegal lengths are rejected without touching the core.
    tick();
    start_block(0);
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!fir_reset || busy) held = 1'b0;
    end
    check_eq("len0_err", 32'(err), 32'd1);
    check_eq("len0_idle", 32'(held), 32'd1);
    tick();
    do_reset();
    start_block(DEPTH - TAIL + 1);
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!fir_reset || busy) held = 1'b0;
    end
    check_eq("lenbig_err", 32'(err), 32'd1);
    check_eq("lenbig_idle", 32'(held), 32'd1);
    tick();
    do_reset();

    // Largest legal block fills the output FIFO exactly.
    push_samples(32'h30, DEPTH - TAIL);
    expect_block(32'h30, DEPTH - TAIL);
    start_block(DEPTH - TAIL);
    @(negedge clk);
    check_eq("lenmax_busy", 32'(busy), 32'd1);
    check_eq("lenmax_err", 32'(err), 32'd0);
    wait_done(200);
    wait_drain(50);

    // Start with only half the block buffered.
    tick();
    push_samples(32'h40, 2);
    expect_block(32'h40, 4);
    start_block(4);
    for (int i = 0; i < 6; i++) tick();
    @(negedge clk);
    check_eq("load_busy", 32'(busy), 32'd1);
    check_eq("load_fir_reset", 32'(fir_reset), 32'd1);
    tick();
    push_samples(32'h42, 2);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!fir_reset) begin
        n = i;
        break;
      end
    end
    check_eq("load_to_run_cycles", 32'(n), 32'(CLR_CYCLES + 2));
    wait_done(100);
    wait_drain(50);

    // Output backpressure holds the next block in LOAD until enough space frees up.
    tick();
    m_ready = 1'b0;
    push_samples(32'h100, 7);
    expect_block(32'h100, 7);
    start_block(7);
    wait_done(100);
    tick();
    push_samples(32'h200, 6);
    expect_block(32'h200, 6);
    start_block(6);
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    check_eq("bp_load_busy", 32'(busy), 32'd1);
    check_eq("bp_load_fir_reset", 32'(fir_reset), 32'd1);
    for (int k = 0; k < 2; k++) begin
      tick();
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
    end
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    check_eq("bp_still_load", 32'(fir_reset), 32'd1);
    tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    held = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!fir_reset) begin
        held = 1'b1;
        break;
      end
    end
    check_eq("bp_released", 32'(held), 32'd1);
    wait_done(100);
    tick();
    m_ready = 1'b1;
    wait_drain(100);

    // Reset mid-RUN clears everything, including queued input.
    tick();
    m_ready = 1'b0;
    push_samples(32'h300, 8);
    start_block(8);
    wait_fir_in(32'h302, 50);
    tick();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_rst_s_ready", 32'(s_ready), 32'd1);
    check_eq("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("mid_rst_m_data", m_data, 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_fir_reset", 32'(fir_reset), 32'd1);
    check_eq("mid_rst_fir_in", fir_in, 32'd0);
    check_eq("mid_rst_err", 32'(err), 32'd0);
    tick();
    reset = 1'b0;
    exp_q.delete();
    m_ready = 1'b1;
    push_samples(32'h400, 2);
    expect_block(32'h400, 2);
    start_block(2);
    wait_done(100);
    wait_drain(50);

`ifdef FIR_BLOCK_SEQ_KEYGATE_EN
    // Key loss during FLUSH aborts the block.
    tick();
    m_ready = 1'b0;
    push_samples(32'h50, 4);
    start_block(4);
    wait_fir_in(32'h53, 50);
    tick();
    d0 = done_cnt;
    key_ready = 1'b0;
    @(negedge clk);
    check_eq("key_abort_err", 32'(err), 32'd1);
    check_eq("key_abort_m_valid", 32'(m_valid), 32'd0);
    check_eq("key_abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 10; i++) tick();
    check_eq("key_abort_no_done", 32'(done_cnt - d0), 32'd0);
    exp_q.delete();
    start_block(4);
    @(negedge clk);
    check_eq("key_reject_busy", 32'(busy), 32'd0);
    tick();
    key_ready = 1'b1;
    m_ready = 1'b1;
`else
    // Without key gating, key_ready has no effect on a block.
    tick();
    key_ready = 1'b0;
    push_samples(32'h60, 3);
    expect_block(32'h60, 3);
    start_block(3);
    wait_done(100);
    wait_drain(50);
    check_eq("nokey_err", 32'(err), 32'd0);
    key_ready = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
